alu_control_seq: RTL
====================

Name: alu_control_seq

Overview:
- Registered, handshaked successor to the combinational ALU control decoder.
- Maps (alu_op, func) to an ALU operation code and sequences multi-cycle multiply for an iterative ALU datapath.
- Sits between decode/ID-EX and the ALU; generalised in field widths and multiply latency.

Parameters:
ALUOP_W, 2, width of alu_op field
FUNC_W, 4, width of func field (minimum 4)
OP_W, 4, width of op output (minimum 4)
MUL_CYCLES, 4, cycles op=MUL is held for iterative multiply (minimum 2)
STEP_W, $clog2(MUL_CYCLES), width of mc_step

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  alu_op/func valid this cycle
in_ready  out  1  block can accept input
alu_op  in  ALUOP_W  class from main control
func  in  FUNC_W  function field
flush  in  1  synchronous kill of current and in-flight ops
clr_err  in  1  clears illegal_err (feature only)
op_valid  out  1  op is valid this cycle
op  out  OP_W  ALU operation code
mc_active  out  1  multiply sequence in progress
mc_step  out  STEP_W  current multiply step, 0..MUL_CYCLES-1
mc_last  out  1  final multiply step
illegal  out  1  registered alongside op: func was undefined
illegal_err  out  1  sticky illegal flag (feature only, else 0)

Behaviour:
- Op codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SLT=7, MUL=8.
- Decode by alu_op:
  - 0 -> ADD (address calc).
  - 1 -> SUB (branch compare).
  - 2 -> R-type: func 0..8 map to op codes 0..8.
  - 3 -> I-type: func 0..7 as R-type; func 8 (MUL) is illegal.
  - Any other func -> op=ADD, illegal=1.
  - alu_op values above 3 when ALUOP_W>2 -> ADD, illegal=1.
- Reset (async, rst_n=0): op_valid=0, op=0, illegal=0, mc_active=0, mc_step=0, mc_last=0, illegal_err=0, state=IDLE. in_ready=1 after release.
- States: IDLE, ISSUE, MULTI.
- Handshake: transfer occurs when in_valid & in_ready & !flush. Decoded result is registered; op_valid=1 the next cycle (latency 1).
- IDLE/ISSUE:
  - in_ready=1.
  - Transfer of a single-cycle op -> ISSUE, op_valid=1 for exactly one cycle.
  - Back-to-back transfers give 1 op/cycle throughput.
  - No transfer -> IDLE, op_valid=0. op and illegal hold their last values.
- Transfer of MUL -> MULTI:
  - op=MUL, op_valid=1, mc_active=1 held for MUL_CYCLES cycles.
  - mc_step increments 0..MUL_CYCLES-1.
  - mc_last=1 only when mc_step=MUL_CYCLES-1.
- MULTI: in_ready = mc_last & !flush.
  - Transfer during mc_last -> next op issues the following cycle, no bubble.
  - No transfer -> IDLE; mc_active, mc_step and mc_last return to 0.
- flush has top priority over input:
  - Next cycle: op_valid=0, mc_active=0, mc_step=0, mc_last=0, state=IDLE.
  - in_ready=0 during the flush cycle.
  - op and illegal hold their values.
- rst_n asserted mid-MULTI aborts immediately to reset values; no partial completion.
- mc_step does not wrap; the counter resets on leaving MULTI.

Optional Feature:
Macro ALU_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - illegal_err sets on any transfer decoding illegal and stays set until clr_err=1.
  - clr_err is synchronous; set wins over a simultaneous clear.
  - Illegal ops still issue as ADD with op_valid=1.
- Not defined:
  - illegal_err tied 0; clr_err ignored.
  - The illegal output still reports per-op.

Test Plan:
1. Reset: rst_n=0, then release -> op_valid=0, op=0, mc_active=0, in_ready=1.
2. alu_op=0 func=1 -> op=0 (ADD) next cycle. alu_op=1 func=0 -> op=1. alu_op=3 func=5 -> op=5. Each has op_valid=1 for one cycle.
3. alu_op=2, func=0..7 on consecutive cycles with in_valid=1 -> op=0..7 on consecutive cycles, op_valid continuously 1, in_ready continuously 1.
4. MUL_CYCLES=4, alu_op=2 func=8, then alu_op=2 func=1 held -> op=8 for 4 cycles with mc_step 0,1,2,3 and mc_last on step 3; in_ready=0 on steps 0-2; op=1 on the 5th cycle.
5. flush at mc_step=1 -> next cycle op_valid=0, mc_active=0, in_ready=1; also rst_n pulsed low mid-MULTI -> all outputs at reset values immediately.
6. alu_op=3 func=8 and alu_op=2 func=15 -> op=0, illegal=1. With the macro defined, illegal_err=1 until clr_err; without it, illegal_err=0.

Source files
------------

// File: rtl/alu_control_seq_if.sv
// ALU control sequencer bus: decode request handshake in, ALU op and multiply sequencing out.
// Ports: in_valid/in_ready/alu_op/func/flush/clr_err (to block), op_valid/op/mc_active/
//        mc_step/mc_last/illegal/illegal_err (from block). master = upstream, slave = block.
interface alu_control_seq_if #(
    parameter int ALUOP_W    = 2,
    parameter int FUNC_W     = 4,
    parameter int OP_W       = 4,
    parameter int MUL_CYCLES = 4,
    parameter int STEP_W     = $clog2(MUL_CYCLES)
);
    logic               in_valid;
    logic               in_ready;
    logic [ALUOP_W-1:0] alu_op;
    logic [FUNC_W-1:0]  func;
    logic               flush;
    logic               clr_err;
    logic               op_valid;
    logic [OP_W-1:0]    op;
    logic               mc_active;
    logic [STEP_W-1:0]  mc_step;
    logic               mc_last;
    logic               illegal;
    logic               illegal_err;

    modport master (
        output in_valid, alu_op, func, flush, clr_err,
        input  in_ready, op_valid, op, mc_active, mc_step, mc_last, illegal, illegal_err
    );

    modport slave (
        input  in_valid, alu_op, func, flush, clr_err,
        output in_ready, op_valid, op, mc_active, mc_step, mc_last, illegal, illegal_err
    );
endinterface

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder: maps (alu_op, func) to an op code and holds MUL for
// MUL_CYCLES cycles with a step counter. Latency 1; in_ready drops during a multiply
// (except on its last step) and during flush. Ports: clk, rst_n, bus (slave modport).
// Optional sticky illegal trap enabled by defining ALU_CTRL_ILLEGAL_TRAP_EN.
module alu_control_seq #(
    parameter int ALUOP_W    = 2,
    parameter int FUNC_W     = 4,
    parameter int OP_W       = 4,
    parameter int MUL_CYCLES = 4,
    parameter int STEP_W     = $clog2(MUL_CYCLES)
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_control_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, MULTI} state_t;

    localparam logic [OP_W-1:0]   OP_ADD    = '0;
    localparam logic [OP_W-1:0]   OP_SUB    = OP_W'(1);
    localparam logic [OP_W-1:0]   OP_MUL    = OP_W'(8);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MUL_CYCLES - 1);

    state_t            state, state_nxt;
    logic [OP_W-1:0]   op_q, dec_op;
    logic              ill_q, dec_ill, dec_mul;
    logic [STEP_W-1:0] step_q;
    logic              at_last, ready_c, transfer;

    // Combinational decode of the presented request.
    always_comb begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
        case (bus.alu_op)
            ALUOP_W'(0): dec_op = OP_ADD;
            ALUOP_W'(1): dec_op = OP_SUB;
            ALUOP_W'(2): begin
                if (bus.func <= FUNC_W'(8)) dec_op = OP_W'(bus.func);
                else                        dec_ill = 1'b1;
            end
            ALUOP_W'(3): begin
                // I-type has no multiply form.
                if (bus.func <= FUNC_W'(7)) dec_op = OP_W'(bus.func);
                else                        dec_ill = 1'b1;
            end
            default: dec_ill = 1'b1;
        endcase
        dec_mul = (dec_op == OP_MUL) && !dec_ill;
    end

    assign at_last  = (state == MULTI) && (step_q == STEP_LAST);
    // Accept only when not mid-multiply; the last multiply step accepts so the
    // next op issues without a bubble. Flush blocks acceptance outright.
    assign ready_c  = ((state != MULTI) || at_last) && !bus.flush;
    assign transfer = bus.in_valid && ready_c;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = IDLE;
        if (bus.flush)                          state_nxt = IDLE;
        else if (transfer)                      state_nxt = dec_mul ? MULTI : ISSUE;
        else if ((state == MULTI) && !at_last)  state_nxt = MULTI;
        else                                    state_nxt = IDLE;
    end

    // Output logic.
    always_comb begin
        bus.in_ready  = ready_c;
        bus.op_valid  = (state != IDLE);
        bus.mc_active = (state == MULTI);
        bus.mc_last   = at_last;
        bus.mc_step   = step_q;
        bus.op        = op_q;
        bus.illegal   = ill_q;
    end

    // Op/illegal are captured on transfer only and hold otherwise (including flush).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_ADD;
            ill_q <= 1'b0;
        end else if (transfer) begin
            op_q  <= dec_op;
            ill_q <= dec_ill;
        end
    end

    // Step counter advances only while a multiply is running; any exit clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            step_q <= '0;
        else if (!bus.flush && !transfer && (state == MULTI) && !at_last)
            step_q <= step_q + STEP_W'(1);
        else
            step_q <= '0;
    end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic err_q;

    // Set has priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  err_q <= 1'b0;
        else if (transfer && dec_ill) err_q <= 1'b1;
        else if (bus.clr_err)        err_q <= 1'b0;
    end

    assign bus.illegal_err = err_q;
`else
    assign bus.illegal_err = 1'b0;
`endif
endmodule
